// File: rtl/weight_fetch_ctrl.sv
// Weight-memory read sequencer: streams one neuron's weights to the MAC through a
// 2-entry FIFO and hands the memory write port to the loader between jobs.
module weight_fetch_ctrl #(
    parameter int unsigned NUM_INPUTS  = 5,
    parameter int unsigned NUM_NEURONS = 1,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned NIDX_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NIDX_W-1:0]             neuron_idx,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic                          w_valid,
    input  logic                          w_ready,
    output logic                          w_last,
    output logic [$clog2(NUM_INPUTS):0]   w_idx,
    output logic                          mem_re,
    output logic [ADDR_WIDTH-1:0]         mem_raddr,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [ADDR_WIDTH-1:0]         load_addr,
    input  logic [DATA_WIDTH-1:0]         load_data,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_waddr,
    output logic [DATA_WIDTH-1:0]         mem_wdata
);

    localparam int unsigned IDX_W = $clog2(NUM_INPUTS) + 1;
    localparam logic [IDX_W-1:0]      N_IDX    = IDX_W'(NUM_INPUTS);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(NUM_INPUTS);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [IDX_W-1:0]       r_issued;
    logic                   r_inflight;
    logic [IDX_W-1:0]       r_inflight_idx;
    logic                   r_done;
    logic                   r_err;

    logic [DATA_WIDTH-1:0]  r_fifo_data [2];
    logic [IDX_W-1:0]       r_fifo_idx  [2];
    logic                   r_fifo_last [2];
    logic                   r_wr_ptr;
    logic                   r_rd_ptr;
    logic [1:0]             r_count;

    logic                   w_pop;
    logic                   w_idx_ok;
    logic [2:0]             w_occ;

    assign w_valid   = (r_count != 2'd0);
    assign w_data    = r_fifo_data[r_rd_ptr];
    assign w_idx     = r_fifo_idx[r_rd_ptr];
    assign w_last    = r_fifo_last[r_rd_ptr];
    assign w_pop     = w_valid & w_ready;
    assign w_idx_ok  = (32'(neuron_idx) < NUM_NEURONS);
    // Slots committed after this cycle: buffered + in flight - leaving now
    assign w_occ     = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign mem_raddr = r_base + ADDR_WIDTH'(r_issued);
    assign mem_we    = load_valid & load_ready;
    assign mem_waddr = load_addr;
    assign mem_wdata = load_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, read issue and write-port grant
    always_comb begin
        w_state_nxt = r_state;
        mem_re      = 1'b0;
        load_ready  = 1'b0;
        case (r_state)
            S_IDLE: begin
                load_ready = ~start;
                if (start && w_idx_ok) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_re = (r_issued < N_IDX) && (w_occ < 3'd2);
                if (mem_re && (r_issued == LAST_IDX)) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pop && w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Job bookkeeping and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base         <= '0;
            r_issued       <= '0;
            r_inflight     <= 1'b0;
            r_inflight_idx <= '0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_done     <= (r_state == S_DRAIN) && w_pop && w_last;
            r_err      <= (r_state == S_IDLE) && start && !w_idx_ok;
            r_inflight <= mem_re;
            if (mem_re) r_inflight_idx <= r_issued;
            if ((r_state == S_IDLE) && start && w_idx_ok) begin
                r_base   <= BASE_A + ADDR_WIDTH'(neuron_idx) * STRIDE_A;
                r_issued <= '0;
            end else if (mem_re) begin
                r_issued <= r_issued + IDX_W'(1);
            end
        end
    end

    // Output FIFO: read data lands one cycle after its mem_re
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_idx[i]  <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= mem_rdata;
                r_fifo_idx[r_wr_ptr]  <= r_inflight_idx;
                r_fifo_last[r_wr_ptr] <= (r_inflight_idx == LAST_IDX);
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({r_inflight, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(r_inflight && !w_pop && (r_count == 2'd2)));

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: spec-level stream model checked every cycle,
// plus directed jobs with literal addresses, beat timing and done latency.
module tb_weight_fetch_ctrl;

    localparam int unsigned NI = 5;
    localparam int unsigned NN = 4;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam int unsigned BA = 16;
    localparam int unsigned NW = 8;
    localparam int unsigned IW = $clog2(NI) + 1;

    logic          clk, rst_n, start;
    logic [NW-1:0] neuron_idx;
    logic          busy, done, err;
    logic [DW-1:0] w_data;
    logic          w_valid, w_ready, w_last;
    logic [IW-1:0] w_idx;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          load_valid, load_ready;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    weight_fetch_ctrl #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW), .BASE_ADDR(BA), .NIDX_W(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_idx(neuron_idx),
        .busy(busy), .done(done), .err(err),
        .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready), .w_last(w_last), .w_idx(w_idx),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr), .load_data(load_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        return DW'((a * 37 + 5) ^ 32'h0000_A5A5);
    endfunction

    // Synchronous weight memory, no reset
    logic [DW-1:0] mem  [1024];
    logic [DW-1:0] gold [1024];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_raddr];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Stream model: what the MAC must see, derived from accepted jobs
    typedef struct { logic [DW-1:0] d; int idx; bit last; } beat_t;
    beat_t exp_beats[$];
    int    exp_addr[$];
    bit    job_active, pend_done, pend_err, re_prev;
    int    issued, popped, landed;

    always @(negedge clk) begin
        bit e_valid, e_pop, e_re, e_ready, e_we, was_active;
        beat_t b;
        if (!rst_n) begin
            exp_beats.delete(); exp_addr.delete();
            job_active = 0; pend_done = 0; pend_err = 0; re_prev = 0;
            issued = 0; popped = 0; landed = 0;
        end else begin
            e_valid = (landed - popped) > 0;
            e_pop   = e_valid && w_ready;
            e_re    = job_active && (exp_addr.size() > 0) &&
                      ((issued - popped - (e_pop ? 1 : 0)) < 2);
            e_ready = !job_active && !start;
            e_we    = load_valid && e_ready;
            chk("busy", 32'(busy), 32'(job_active));
            chk("done", 32'(done), 32'(pend_done));
            chk("err", 32'(err), 32'(pend_err));
            chk("w_valid", 32'(w_valid), 32'(e_valid));
            chk("mem_re", 32'(mem_re), 32'(e_re));
            chk("load_ready", 32'(load_ready), 32'(e_ready));
            chk("mem_we", 32'(mem_we), 32'(e_we));
            if (e_re) chk("mem_raddr", 32'(mem_raddr), 32'(exp_addr[0]));
            if (e_we) begin
                chk("mem_waddr", 32'(mem_waddr), 32'(load_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(load_data));
            end
            if (e_valid && exp_beats.size() > 0) begin
                chk("w_data", 32'(w_data), 32'(exp_beats[0].d));
                chk("w_idx", 32'(w_idx), 32'(exp_beats[0].idx));
                chk("w_last", 32'(w_last), 32'(exp_beats[0].last));
            end
            // Advance the model across the coming edge
            was_active = job_active;
            pend_err   = start && !was_active && (32'(neuron_idx) >= NN);
            pend_done  = 0;
            landed    += (re_prev ? 1 : 0);
            re_prev    = e_re;
            if (e_re) begin
                void'(exp_addr.pop_front());
                issued++;
            end
            if (e_pop && exp_beats.size() > 0) begin
                b = exp_beats.pop_front();
                popped++;
                if (b.last) begin
                    job_active = 0;
                    pend_done  = 1;
                end
            end
            if (e_we) gold[load_addr] = load_data;
            if (start && !was_active && (32'(neuron_idx) < NN)) begin
                job_active = 1;
                for (int i = 0; i < int'(NI); i++) begin
                    int a;
                    a = int'((BA + 32'(neuron_idx) * NI + 32'(i)) % 1024);
                    exp_addr.push_back(a);
                    exp_beats.push_back('{d: gold[a], idx: i, last: (i == int'(NI) - 1)});
                end
            end
        end
    end

    task automatic start_job(input int idx);
        @(posedge clk); #1;
        start = 1'b1; neuron_idx = NW'(idx);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Full-rate job with literal expectations for addresses, beats and done latency
    task automatic run_literal(input int idx, input int base);
        int n_re, n_b, n_done;
        n_re = 0; n_b = 0; n_done = 0;
        w_ready = 1'b1;
        start_job(idx);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_re) begin
                chk("lit_raddr", 32'(mem_raddr), 32'(base + n_re));
                chk("lit_re_cycle", 32'(c), 32'(n_re));
                n_re++;
            end
            if (w_valid) begin
                chk("lit_beat_cycle", 32'(c), 32'(n_b + 2));
                chk("lit_idx", 32'(w_idx), 32'(n_b));
                chk("lit_last", 32'(w_last), 32'(n_b == 4));
                chk("lit_data", 32'(w_data), 32'(pat(base + n_b)));
                n_b++;
            end
            if (done) begin
                chk("lit_done_cycle", 32'(c), 32'd7);
                chk("lit_busy_at_done", 32'(busy), 32'd0);
                n_done++;
            end
        end
        chk("lit_n_reads", 32'(n_re), 32'd5);
        chk("lit_n_beats", 32'(n_b), 32'd5);
        chk("lit_n_done", 32'(n_done), 32'd1);
    endtask

    // Wait for done with a cycle budget; optionally randomise w_ready meanwhile
    task automatic wait_done(input int max_cyc, input bit rnd);
        bit seen;
        seen = 0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
            if (rnd) w_ready = 1'($urandom_range(0, 1));
        end
        chk("done_timeout", 32'(seen), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = pat(i);
            gold[i] = pat(i);
        end
        rst_n = 1'b0; start = 1'b0; neuron_idx = '0; w_ready = 1'b0;
        load_valid = 1'b0; load_addr = '0; load_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(w_valid), 32'd0);
        chk("rst_re", 32'(mem_re), 32'd0);
        chk("rst_raddr", 32'(mem_raddr), 32'd0);
        chk("rst_idx", 32'(w_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Directed full-rate jobs: neuron 2 -> 26..30, neuron 0 -> 16..20
        run_literal(2, 26);
        run_literal(0, 16);

        // Out-of-range neuron index
        start_job(4);
        @(negedge clk);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_no_re", 32'(mem_re), 32'd0);
        @(negedge clk);
        chk("err_one_shot", 32'(err), 32'd0);
        chk("err_busy2", 32'(busy), 32'd0);

        // Backpressure: random w_ready over several jobs
        for (int j = 0; j < 4; j++) begin
            w_ready = 1'($urandom_range(0, 1));
            start_job((j * 3 + 1) % 4);
            wait_done(200, 1'b1);
        end

        // Loader held high across a job; start wins, write resumes after the job
        @(posedge clk); #1;
        w_ready = 1'b1; load_valid = 1'b1; load_addr = AW'(22); load_data = 16'hBEEF;
        @(negedge clk);
        chk("ld_idle_ready", 32'(load_ready), 32'd1);
        chk("ld_idle_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        start = 1'b1; neuron_idx = NW'(1);
        @(negedge clk);
        chk("ld_start_ready", 32'(load_ready), 32'd0);
        chk("ld_start_we", 32'(mem_we), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(50, 1'b0);
        chk("ld_done_ready", 32'(load_ready), 32'd1);
        chk("ld_done_we", 32'(mem_we), 32'd1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        start_job(1);
        wait_done(200, 1'b1);

        // Reset during the third beat with a read in flight
        w_ready = 1'b1;
        start_job(3);
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(w_valid), 32'd0);
        chk("mid_rst_re", 32'(mem_re), 32'd0);
        chk("mid_rst_raddr", 32'(mem_raddr), 32'd0);
        chk("mid_rst_idx", 32'(w_idx), 32'd0);
        chk("mid_rst_last", 32'(w_last), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        run_literal(3, 31);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Sequencer in front of the weight memory (synchronous read, 1-cycle latency, no reset).
- On a start request for one neuron, it issues NUM_INPUTS consecutive weight reads and presents the weights as a valid/ready stream to the neuron MAC.
- Between jobs, it arbitrates the memory write port for the weight loader.
- Read latency and downstream backpressure are absorbed by a 2-entry output FIFO.

Parameters:
- NUM_INPUTS, 5, weights per neuron (>=1).
- NUM_NEURONS, 1, neurons in the layer (>=1).
- ADDR_WIDTH, 10, memory address width.
- DATA_WIDTH, 16, weight width.
- BASE_ADDR, 0, address of neuron 0 weight 0.
- NIDX_W, 8, width of neuron_idx.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request fetch of one neuron's weights (sampled in IDLE only)
- neuron_idx  in  NIDX_W  neuron to fetch, sampled with start
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse, job complete
- err  out  1  one-cycle pulse, start rejected
- w_data  out  DATA_WIDTH  weight to MAC (FIFO head)
- w_valid  out  1  w_data valid
- w_ready  in  1  MAC accepts
- w_last  out  1  head is weight NUM_INPUTS-1
- w_idx  out  $clog2(NUM_INPUTS)+1  input index of head
- mem_re  out  1  memory read_enable
- mem_raddr  out  ADDR_WIDTH  memory read_addr
- mem_rdata  in  DATA_WIDTH  memory read_data
- load_valid  in  1  loader write request
- load_ready  out  1  write accepted this cycle
- load_addr  in  ADDR_WIDTH  write address
- load_data  in  DATA_WIDTH  write data
- mem_we  out  1  memory write_enable
- mem_waddr  out  ADDR_WIDTH  memory write_addr
- mem_wdata  out  DATA_WIDTH  memory write_data

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; FIFO empty; issue/in-flight counters 0.
  - busy, done, err, w_valid, mem_re, mem_we = 0; mem_raddr=0; w_idx=0.
  - Reset mid-job aborts the job; the in-flight read is discarded; no done pulse.
- States IDLE, FETCH, DRAIN:
  - IDLE & start & neuron_idx<NUM_NEURONS:
    - latch base = BASE_ADDR + neuron_idx*NUM_INPUTS (ADDR_WIDTH, truncated);
    - issued=0; go to FETCH.
  - IDLE & start & neuron_idx>=NUM_NEURONS: err=1 next cycle; stay in IDLE.
  - FETCH → DRAIN on the edge where the last read issues (issued reaches NUM_INPUTS).
  - DRAIN → IDLE on the edge where the w_last beat handshakes (w_valid & w_ready & w_last).
  - done=1 the cycle after that edge; busy=0 the same cycle.
- Read issue:
  - mem_re = (state==FETCH) & (issued<NUM_INPUTS) & (fifo_count + inflight - pop < 2).
  - pop = w_valid & w_ready. inflight (0/1) = mem_re registered.
  - mem_raddr = base + issued, combinational from registers.
  - issued increments on each mem_re.
- Data capture:
  - In the cycle after mem_re, mem_rdata is pushed into the FIFO with its index and a last flag.
  - Push and pop in the same cycle are allowed. Overflow is impossible by the issue rule; assert it in simulation.
- Output:
  - w_data, w_idx, w_last are the FIFO head; w_valid = fifo_count>0.
  - Head is stable while w_valid & !w_ready.
- Latency:
  - With start sampled at edge E0, mem_re is high in cycle E0..E1.
  - First w_valid is high from E2, with data captured at E2.
- Throughput: 1 weight/cycle with w_ready held high. A job takes NUM_INPUTS+2 cycles from start to the last beat.
- Write arbitration:
  - load_ready = (state==IDLE) & !start. Start wins over a simultaneous load.
  - mem_we = load_valid & load_ready; mem_waddr/mem_wdata pass through load_addr/load_data combinationally.
  - No writes occur while busy, so weights cannot change mid-job.
- start while busy: ignored, no err.
- NUM_INPUTS=1: the single beat has w_last=1 and w_idx=0.

Test Plan:
- Reset, then start with neuron_idx=0, NUM_INPUTS=5, w_ready=1 → mem_raddr 0..4 on consecutive cycles; w_data equals mem[0..4]; w_idx 0..4; w_last only on idx 4; done pulses once, 8 cycles after start.
- NUM_NEURONS=4, neuron_idx=2, BASE_ADDR=16 → reads addresses 26..30.
- w_ready toggled 1,0,0,1 randomly → never more than 2 beats outstanding; no data lost or duplicated; head stable while stalled; exact sequence preserved.
- start with neuron_idx=NUM_NEURONS → err pulses once; no mem_re; busy stays 0.
- load_valid held high with start pulsed in IDLE → load_ready=0 in the start cycle and during the job; write resumes the cycle after done; mem_we never coincides with busy.
- rst_n asserted during the 3rd beat with a read in flight → all outputs 0 immediately; a new start after release fetches cleanly from issued=0.
